mem_responder: RTL

Memory-side responder for the LC-3 datapath's control strobes. It accepts the controller's active-low chip/byte/output/write enables and the MAR address, and answers as a fixed-latency 16-bit word memory: read data is valid on the second consecutive OE cycle, which lets MDR load it. Writes commit once per WE assertion, under byte-lane control. A side load port fills program memory while the CPU holds the bus idle.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_array.sv | 34 +++
 rtl/mem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
// Holds the FSM state encoding and the byte-lane mask helpers.
package mem_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  // Lane select vectors, bit 1 = upper byte, bit 0 = lower byte (active-high).
  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_BOTH = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD1     = 3'd1,
    RD2     = 3'd2,
    WR      = 3'd3,
    WR_HOLD = 3'd4
  } mem_state_t;

  function automatic logic [WORD_W-1:0] lane_mask(input logic [1:0] lanes);
    return {{BYTE_W{lanes[1]}}, {BYTE_W{lanes[0]}}};
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM split into two byte-wide lanes.
// Each lane has its own write enable; the read port is registered (read-first).
import mem_pkg::*;

module mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [BYTE_W-1:0] mem_lane [DEPTH];
      logic [BYTE_W-1:0] rd_reg;

      always_ff @(posedge Clk) begin
        if (we[gi]) begin
          mem_lane[addr] <= wdata[gi*BYTE_W +: BYTE_W];
        end
        rd_reg <= mem_lane[addr];
      end

      assign rdata[gi*BYTE_W +: BYTE_W] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency 16-bit memory answering the LC-3 controller's active-low strobes,
// with a side loader that shares the array port while the CPU bus is idle.
import mem_pkg::*;

module mem_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_valid,
  input  logic              Load_en,
  input  logic [ADDR_W-1:0] Load_addr,
  input  logic [DATA_W-1:0] Load_data,
  output logic              Load_ack
);

  mem_state_t        state_reg, state_next;
  logic [DATA_W-1:0] data_out_reg;
  logic              data_valid_reg;
  logic              load_ack_reg;

  logic              cpu_wr;
  logic              load_accept;
  logic [1:0]        cpu_lanes;
  logic [1:0]        port_we;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_wdata;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    state_next = state_reg;
    if (Mem_CE) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!Mem_WE)      state_next = WR;
          else if (!Mem_OE) state_next = RD1;
        end
        RD1, RD2: begin
          state_next = (!Mem_OE && Mem_WE) ? RD2 : IDLE;
        end
        WR:      state_next = WR_HOLD;
        WR_HOLD: if (Mem_WE) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The commit happens on the edge that enters WR; a coincident Reset cancels it.
  assign cpu_wr      = (state_reg == IDLE) && !Mem_CE && !Mem_WE && !Reset;
  assign load_accept = (state_reg == IDLE) && Mem_CE && Load_en && !Reset;
  assign cpu_lanes   = {~Mem_UB, ~Mem_LB};

  always_comb begin
    port_addr  = Addr;
    port_wdata = Data_in;
    port_we    = cpu_wr ? cpu_lanes : LANE_NONE;
    if (load_accept) begin
      port_addr  = Load_addr;
      port_wdata = Load_data;
      port_we    = LANE_BOTH;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem_array (
    .Clk  (Clk),
    .we   (port_we),
    .addr (port_addr),
    .wdata(port_wdata),
    .rdata(rd_data)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= IDLE;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      load_ack_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      load_ack_reg <= load_accept;
      // Only RD2 presents data; every other state drives a clean zero.
      if (state_next == RD2) begin
        data_out_reg   <= rd_data & lane_mask(cpu_lanes);
        data_valid_reg <= 1'b1;
      end else begin
        data_out_reg   <= '0;
        data_valid_reg <= 1'b0;
      end
    end
  end

  assign Data_out   = data_out_reg;
  assign Data_valid = data_valid_reg;
  assign Load_ack   = load_ack_reg;

endmodule
